// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus bundle for mem_access_unit.
// The master modport is the sequencer; the slave modport is the CPU plus the memory.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;
  logic [17:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte_operations;

  modport master (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, busy,
    output mem_address, mem_write_data, mem_read, mem_write, mem_byte_operations
  );

  modport slave (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, busy,
    input  mem_address, mem_write_data, mem_read, mem_write, mem_byte_operations
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer driving the shared data-memory bus with timed strobes.
// Define MEM_ACCESS_RMW_EN to turn byte stores into a word read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
`ifdef MEM_ACCESS_RMW_EN
  localparam logic [2:0] RMW_RD = 3'd4;
  localparam logic [2:0] RMW_WR = 3'd5;
`endif

  localparam logic [3:0] LAST_CNT = 4'(MEM_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, byte_q, signed_q;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        phase_end;
  logic        accept;
  logic        rd_phase;
  logic [7:0]  lane;
  logic [31:0] load_data;

  assign phase_end = (cnt_q == LAST_CNT);
  assign accept    = (state_q == IDLE) && bus.req_valid;
`ifdef MEM_ACCESS_RMW_EN
  assign rd_phase  = (state_q == RD) || (state_q == RMW_RD);
`else
  assign rd_phase  = (state_q == RD);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!bus.req_write) begin
            state_d = RD;
          end else begin
`ifdef MEM_ACCESS_RMW_EN
            state_d = bus.req_byte ? RMW_RD : WR;
`else
            state_d = WR;
`endif
          end
        end
      end
      RD, WR: begin
        if (phase_end) state_d = DONE;
        else           cnt_d   = cnt_q + 4'd1;
      end
`ifdef MEM_ACCESS_RMW_EN
      // Write phase follows the read directly so the merged word is never stale.
      RMW_RD: begin
        if (phase_end) state_d = RMW_WR;
        else           cnt_d   = cnt_q + 4'd1;
      end
      RMW_WR: begin
        if (phase_end) state_d = DONE;
        else           cnt_d   = cnt_q + 4'd1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= bus.req_write;
        byte_q   <= bus.req_byte;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      if (rd_phase && phase_end) rdata_q <= bus.mem_read_data;
    end
  end

  // Odd address selects the low byte of the halfword.
  assign lane      = addr_q[0] ? rdata_q[7:0] : rdata_q[15:8];
  assign load_data = byte_q ? {{24{signed_q & lane[7]}}, lane} : rdata_q;

  always_comb begin
    bus.req_ready           = (state_q == IDLE);
    bus.busy                = (state_q != IDLE);
    bus.resp_valid          = 1'b0;
    bus.resp_rdata          = '0;
    bus.mem_address         = '0;
    bus.mem_write_data      = '0;
    bus.mem_read            = 1'b0;
    bus.mem_write           = 1'b0;
    bus.mem_byte_operations = 1'b0;
    case (state_q)
      RD: begin
        bus.mem_read            = 1'b1;
        bus.mem_address         = addr_q;
        bus.mem_byte_operations = byte_q;
      end
      WR: begin
        bus.mem_write           = 1'b1;
        bus.mem_address         = addr_q;
        bus.mem_byte_operations = byte_q;
        bus.mem_write_data      = byte_q ? {16'h0000, wdata_q[7:0], wdata_q[7:0]} : wdata_q;
      end
`ifdef MEM_ACCESS_RMW_EN
      RMW_RD: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {1'b0, addr_q[17:1]};
      end
      RMW_WR: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = {1'b0, addr_q[17:1]};
        bus.mem_write_data = addr_q[0] ? {rdata_q[31:8], wdata_q[7:0]}
                                       : {rdata_q[31:16], wdata_q[7:0], rdata_q[7:0]};
      end
`endif
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = write_q ? 32'h0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with MEM_CYCLES = 2; expectations are hand-computed.
// Byte-store expectations follow MEM_ACCESS_RMW_EN when it is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_word = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Per-access observations gathered cycle by cycle after the accept edge.
  int          rd_n, wr_n, first_rd, last_rd, first_wr, resp_cycle, resp_n;
  logic [17:0] rd_addr, wr_addr;
  logic        rd_bo, wr_bo, overlap, wr_unstable, busy1, ready_after;
  logic [31:0] wr_data, resp_data;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_read_data = mem_word;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_access(input logic w, input logic b, input logic s,
                            input logic [17:0] a, input logic [31:0] wd, input logic [31:0] mw);
    @(negedge clk);
    mem_word       = mw;
    bus.req_write  = w;
    bus.req_byte   = b;
    bus.req_signed = s;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    check("ready_before_accept", 32'(bus.req_ready), 32'd1);
    rd_n = 0; wr_n = 0; first_rd = 0; last_rd = 0; first_wr = 0;
    resp_cycle = 0; resp_n = 0; rd_addr = '0; wr_addr = '0; rd_bo = 0; wr_bo = 0;
    overlap = 0; wr_unstable = 0; wr_data = '0; resp_data = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble inputs to prove the latched copy is used.
        bus.req_valid  = 1'b0;
        bus.req_write  = ~w;
        bus.req_byte   = ~b;
        bus.req_signed = ~s;
        bus.req_addr   = ~a;
        bus.req_wdata  = ~wd;
        busy1          = bus.busy;
      end
      if (bus.mem_read && bus.mem_write) overlap = 1'b1;
      if (bus.mem_read) begin
        rd_n++;
        if (first_rd == 0) first_rd = c;
        last_rd = c;
        rd_addr = bus.mem_address;
        rd_bo   = bus.mem_byte_operations;
      end
      if (bus.mem_write) begin
        if (wr_n > 0 && bus.mem_write_data !== wr_data) wr_unstable = 1'b1;
        wr_n++;
        if (first_wr == 0) first_wr = c;
        wr_addr = bus.mem_address;
        wr_data = bus.mem_write_data;
        wr_bo   = bus.mem_byte_operations;
      end
      if (bus.resp_valid) begin
        resp_n++;
        if (resp_cycle == 0) begin
          resp_cycle = c;
          resp_data  = bus.resp_rdata;
        end
      end
    end
    ready_after = bus.req_ready;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_byte   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a read phase aborts it.
    @(negedge clk);
    mem_word      = 32'h55AA55AA;
    bus.req_write = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 18'h00030;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_pre_read", 32'(bus.mem_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_read_drop", 32'(bus.mem_read), 32'd0);
    check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    resp_n = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) resp_n++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) resp_n++;
    end
    check("abort_resp_count", 32'(resp_n), 32'd0);

    // Word load.
    run_access(1'b0, 1'b0, 1'b0, 18'h00010, 32'h0, 32'hDEADBEEF);
    check("wl_busy", 32'(busy1), 32'd1);
    check("wl_rd_cycles", 32'(rd_n), 32'd2);
    check("wl_first_rd", 32'(first_rd), 32'd1);
    check("wl_wr_cycles", 32'(wr_n), 32'd0);
    check("wl_addr", 32'(rd_addr), 32'h00010);
    check("wl_byte_mode", 32'(rd_bo), 32'd0);
    check("wl_resp_cycle", 32'(resp_cycle), 32'd3);
    check("wl_resp_count", 32'(resp_n), 32'd1);
    check("wl_rdata", resp_data, 32'hDEADBEEF);
    check("wl_ready_after", 32'(ready_after), 32'd1);

    // Byte loads: odd address takes [7:0], even takes [15:8].
    run_access(1'b0, 1'b1, 1'b1, 18'h00021, 32'h0, 32'h00000080);
    check("bls_addr", 32'(rd_addr), 32'h00021);
    check("bls_byte_mode", 32'(rd_bo), 32'd1);
    check("bls_rdata", resp_data, 32'hFFFFFF80);
    run_access(1'b0, 1'b1, 1'b0, 18'h00021, 32'h0, 32'h00000080);
    check("blu_rdata", resp_data, 32'h00000080);
    run_access(1'b0, 1'b1, 1'b1, 18'h00020, 32'h0, 32'h00007F00);
    check("ble_rdata", resp_data, 32'h0000007F);
    check("ble_resp_cycle", 32'(resp_cycle), 32'd3);

    // Word store.
    run_access(1'b1, 1'b0, 1'b0, 18'h00004, 32'h12345678, 32'hCAFEF00D);
    check("ws_wr_cycles", 32'(wr_n), 32'd2);
    check("ws_rd_cycles", 32'(rd_n), 32'd0);
    check("ws_overlap", 32'(overlap), 32'd0);
    check("ws_addr", 32'(wr_addr), 32'h00004);
    check("ws_data", wr_data, 32'h12345678);
    check("ws_stable", 32'(wr_unstable), 32'd0);
    check("ws_byte_mode", 32'(wr_bo), 32'd0);
    check("ws_resp_cycle", 32'(resp_cycle), 32'd3);
    check("ws_rdata", resp_data, 32'd0);

    // Byte store.
    run_access(1'b1, 1'b1, 1'b0, 18'h00009, 32'hFFFFFFAB, 32'h11223344);
    check("bs_overlap", 32'(overlap), 32'd0);
    check("bs_wr_cycles", 32'(wr_n), 32'd2);
    check("bs_stable", 32'(wr_unstable), 32'd0);
    check("bs_rdata", resp_data, 32'd0);
    check("bs_resp_count", 32'(resp_n), 32'd1);
`ifdef MEM_ACCESS_RMW_EN
    check("bs_rd_cycles", 32'(rd_n), 32'd2);
    check("bs_rd_addr", 32'(rd_addr), 32'h00004);
    check("bs_rd_byte_mode", 32'(rd_bo), 32'd0);
    check("bs_wr_addr", 32'(wr_addr), 32'h00004);
    check("bs_wr_byte_mode", 32'(wr_bo), 32'd0);
    check("bs_data", wr_data, 32'h112233AB);
    check("bs_no_gap", 32'(first_wr), 32'(last_rd + 1));
    check("bs_resp_cycle", 32'(resp_cycle), 32'd5);
`else
    check("bs_rd_cycles", 32'(rd_n), 32'd0);
    check("bs_wr_addr", 32'(wr_addr), 32'h00009);
    check("bs_wr_byte_mode", 32'(wr_bo), 32'd1);
    check("bs_data", wr_data, 32'h0000ABAB);
    check("bs_resp_cycle", 32'(resp_cycle), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
